// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product as hi/lo.
// Borrows an external WIDTH-bit adder each cycle through add_x/add_y/add_cin/add_sum.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               last_step;
  logic               ovf;
  logic               shift_in;
  logic [WIDTH-1:0]   a_shifted;
  logic [WIDTH-1:0]   q_shifted;

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // The adder drops the 33rd bit; recover the true sign when the add overflows.
  assign ovf       = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_x[WIDTH-1]);
  assign shift_in  = ovf ? ~add_sum[WIDTH-1] : add_sum[WIDTH-1];
  assign a_shifted = {shift_in, add_sum[WIDTH-1:1]};
  assign q_shifted = {add_sum[0], q_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      StRun: begin
        busy  = 1'b1;
        add_x = a_q;
        unique case ({q_q[0], qm1_q})
          2'b01: begin
            add_y = m_q;
          end
          2'b10: begin
            add_y   = ~m_q;
            add_cin = 1'b1;
          end
          default: begin
            add_y   = '0;
            add_cin = 1'b0;
          end
        endcase
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = '0;
          q_d   = multiplier;
          m_d   = multiplicand;
          qm1_d = 1'b0;
          cnt_d = '0;
        end
      end
      StRun: begin
        a_d   = a_shifted;
        q_d   = q_shifted;
        qm1_d = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          hi_d = a_shifted;
          lo_d = q_shifted;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: random and directed products against a 64-bit
// reference, plus per-cycle adder-port checks derived from partial Booth sums.
module tb_booth_multiplier;

  localparam int unsigned Width = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [Width-1:0]  multiplicand = '0;
  logic [Width-1:0]  multiplier = '0;
  logic              busy, done, add_cin;
  logic [Width-1:0]  hi, lo, add_x, add_y, add_sum;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  // Behavioural model of the external adder
  assign add_sum = add_x + add_y + {{(Width-1){1'b0}}, add_cin};

  booth_multiplier #(.WIDTH(Width), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .add_x        (add_x),
    .add_y        (add_y),
    .add_cin      (add_cin),
    .add_sum      (add_sum)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sext(input logic [31:0] v);
    return longint'({{32{v[31]}}, v});
  endfunction

  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
    return 64'(sext(m) * sext(q));
  endfunction

  // Accumulator after k steps: M times the signed value of Q's low k bits, scaled by 2^-k.
  function automatic logic [31:0] ref_acc(input logic [31:0] m, input logic [31:0] q,
                                          input int k);
    longint vk;
    longint p;
    if (k == 0) return 32'h0;
    vk = (sext(q) <<< (64 - k)) >>> (64 - k);
    p  = (sext(m) * vk) >>> k;
    return p[31:0];
  endfunction

  function automatic logic [32:0] ref_ycin(input logic [31:0] m, input logic [31:0] q,
                                           input int k);
    logic prev;
    prev = (k == 0) ? 1'b0 : q[k-1];
    case ({q[k], prev})
      2'b01:   return {m, 1'b0};
      2'b10:   return {~m, 1'b1};
      default: return 33'h0;
    endcase
  endfunction

  // Full operation from IDLE; called at a negedge, returns at the negedge after DONE.
  task automatic do_mul(input logic [31:0] m, input logic [31:0] q);
    logic [63:0] p;
    p = ref_prod(m, q);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("busy_run", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      chk("add_x", 64'(add_x), 64'(ref_acc(m, q, k)));
      chk("add_y_cin", 64'({add_y, add_cin}), 64'(ref_ycin(m, q, k)));
      @(negedge clk);
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd1);
    chk("product", {hi, lo}, p);
    @(negedge clk);
    chk("done_low", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("product_hold", {hi, lo}, p);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, 64'd0);
    chk({tag, "_add"}, 64'({add_x, add_y, add_cin}), 64'd0);
  endtask

  initial begin
    logic [31:0] m, q;
    int cyc;
    logic [31:0] edge_vals [5];
    edge_vals[0] = 32'h0;
    edge_vals[1] = 32'h1;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF;

    // Reset
    #2 rst = 1'b1;
    #1 check_idle_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    // Directed products
    do_mul(32'd6, 32'd7);
    chk("basic_lo", 64'(lo), 64'h2A);
    do_mul(32'hFFFF_FFFD, 32'd5);
    chk("mixed_a", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_mul(32'd5, 32'hFFFF_FFFD);
    chk("mixed_b", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_mul(32'h8000_0000, 32'h8000_0000);
    chk("min_min", {hi, lo}, 64'h4000_0000_0000_0000);
    do_mul(32'h8000_0000, 32'hFFFF_FFFF);
    chk("min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);
    do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    chk("max_max", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

    // start during RUN and during DONE must be ignored
    start = 1'b1;
    multiplicand = 32'd1234;
    multiplier = 32'hFFFF_FF00;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 5) begin
        start = 1'b1;
        multiplicand = 32'd99;
        multiplier = 32'd77;
      end else if (k == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_product", {hi, lo}, ref_prod(32'd1234, 32'hFFFF_FF00));
    start = 1'b1;
    multiplicand = 32'd55;
    multiplier = 32'd66;
    @(negedge clk);
    start = 1'b0;
    chk("ign_idle_busy", 64'(busy), 64'd0);
    chk("ign_hold", {hi, lo}, ref_prod(32'd1234, 32'hFFFF_FF00));
    @(negedge clk);
    chk("ign_still_idle", 64'(busy), 64'd0);

    // Back-to-back with start held high
    start = 1'b1;
    multiplicand = 32'hDEAD_BEEF;
    multiplier = 32'h0000_1357;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    chk("b2b_first_lat", 64'(cyc), 64'd33);
    chk("b2b_first", {hi, lo}, ref_prod(32'hDEAD_BEEF, 32'h0000_1357));
    multiplicand = 32'hFFFF_0001;
    multiplier = 32'h8000_0001;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    chk("b2b_period", 64'(cyc), 64'd34);
    chk("b2b_second", {hi, lo}, ref_prod(32'hFFFF_0001, 32'h8000_0001));
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'd0);

    // Reset in the middle of an operation
    start = 1'b1;
    multiplicand = 32'h1234_5678;
    multiplier = 32'hFFFF_0F0F;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst_after");
    do_mul(32'd2, 32'd3);
    chk("midrst_new_lo", 64'(lo), 64'd6);

    // Random signed pairs, with boundary values mixed in
    for (int i = 0; i < 1000; i++) begin
      m = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      q = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      do_mul(m, q);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
